demux4_tdm: RTL and testbench

Receive-side counterpart of the 4:1 mux merge cell. It takes a time-division-multiplexed stream carrying four slots per frame, locks onto a frame-sync marker, and steers each slot into its own register. Complete frames are presented on four parallel outputs with a one-cycle strobe. It sits at the far end of a serial or narrow link whose transmit side is built from mux4 cells driven by a slot counter.

---
 rtl/demux4_tdm_pkg.sv | 9 +
 rtl/demux4_tdm_if.sv | 20 ++
 rtl/demux4_shadow_reg.sv | 31 +++
 rtl/demux4_tdm.sv | 98 +++++++++
 tb/tb_demux4_tdm.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/demux4_tdm_pkg.sv
// demux4_tdm_pkg: shared types and constants for the 4-slot TDM demultiplexer.
//   NUM_SLOTS  - slots per frame
//   slot_idx_t - slot index type
//   state_t    - framing FSM state (HUNT: searching for sync, LOCKED: aligned)
package demux4_tdm_pkg;
  localparam int NUM_SLOTS = 4;
  typedef logic [1:0] slot_idx_t;
  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;
endpackage

// File: rtl/demux4_tdm_if.sv
// demux4_tdm_if: stream-in / frame-out bundle for demux4_tdm.
//   d_i, valid_i, sync_i             - TDM slot stream (driven by master)
//   y_o, frame_valid_o, locked_o,
//   slot_o, sync_err_o               - decoded frame and status (driven by slave)
interface demux4_tdm_if #(parameter int WIDTH = 1);
  import demux4_tdm_pkg::*;
  logic [WIDTH-1:0]   d_i;
  logic               valid_i;
  logic               sync_i;
  logic [4*WIDTH-1:0] y_o;
  logic               frame_valid_o;
  logic               locked_o;
  slot_idx_t          slot_o;
  logic               sync_err_o;

  modport master (output d_i, valid_i, sync_i,
                  input  y_o, frame_valid_o, locked_o, slot_o, sync_err_o);
  modport slave  (input  d_i, valid_i, sync_i,
                  output y_o, frame_valid_o, locked_o, slot_o, sync_err_o);
endinterface

// File: rtl/demux4_shadow_reg.sv
// demux4_shadow_reg: holds slots 0..2 of the frame being assembled.
//   clk_i, rst_i - clock, sync active-high reset
//   clr_i        - synchronous clear of all entries
//   we_i         - one-hot write enable, bit k writes entry k
//   d_i          - slot data
//   q_o          - entries, q_o[k] = slot k
module demux4_shadow_reg #(parameter int WIDTH = 1) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic [2:0]            we_i,
  input  logic [WIDTH-1:0]      d_i,
  output logic [2:0][WIDTH-1:0] q_o
);
  logic [2:0][WIDTH-1:0] shadow_q, shadow_d;

  // A write in the same cycle as a clear wins: early sync drops the partial
  // frame but keeps the new slot 0.
  always_comb begin
    shadow_d = clr_i ? '0 : shadow_q;
    for (int k = 0; k < 3; k++)
      if (we_i[k]) shadow_d[k] = d_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) shadow_q <= '0;
    else       shadow_q <= shadow_d;
  end

  assign q_o = shadow_q;
endmodule

// File: rtl/demux4_tdm.sv
// demux4_tdm: locks onto a 4-slot TDM stream via sync marker and presents
// complete frames in parallel with a one-cycle strobe.
//   clk_i, rst_i - clock, sync active-high reset
//   bus (slave)  - d_i/valid_i/sync_i in; y_o/frame_valid_o/locked_o/
//                  slot_o/sync_err_o out (all registered)
module demux4_tdm
  import demux4_tdm_pkg::*;
#(parameter int WIDTH = 1) (
  input  logic         clk_i,
  input  logic         rst_i,
  demux4_tdm_if.slave  bus
);
  state_t             state_q, state_d;
  slot_idx_t          slot_q, slot_d;
  logic [4*WIDTH-1:0] y_q, y_d;
  logic               fv_q, fv_d;
  logic               err_q, err_d;
  logic [2:0]         we;
  logic               clr;
  logic [2:0][WIDTH-1:0] shadow;

  demux4_shadow_reg #(.WIDTH(WIDTH)) u_shadow (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clr),
    .we_i  (we),
    .d_i   (bus.d_i),
    .q_o   (shadow)
  );

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    y_d     = y_q;
    fv_d    = 1'b0;
    err_d   = 1'b0;
    we      = 3'b000;
    clr     = 1'b0;
    if (bus.valid_i) begin
      unique case (state_q)
        HUNT: begin
          if (bus.sync_i) begin
            we      = 3'b001;
            slot_d  = slot_idx_t'(1);
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (bus.sync_i) begin
            // Sync anywhere but slot 0 drops the partial frame and restarts.
            if (slot_q != '0) begin
              err_d = 1'b1;
              clr   = 1'b1;
            end
            we     = 3'b001;
            slot_d = slot_idx_t'(1);
          end else if (slot_q == '0) begin
            err_d   = 1'b1;
            clr     = 1'b1;
            state_d = HUNT;
            slot_d  = '0;
          end else if (slot_q == slot_idx_t'(NUM_SLOTS-1)) begin
            // Last slot bypasses the shadow bank straight into the output.
            y_d    = {bus.d_i, shadow};
            fv_d   = 1'b1;
            slot_d = '0;
          end else begin
            we     = 3'b001 << slot_q;
            slot_d = slot_q + slot_idx_t'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= HUNT;
      slot_q  <= '0;
      y_q     <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      y_q     <= y_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
    end
  end

  assign bus.y_o           = y_q;
  assign bus.frame_valid_o = fv_q;
  assign bus.locked_o      = (state_q == LOCKED);
  assign bus.slot_o        = slot_q;
  assign bus.sync_err_o    = err_q;
endmodule

// File: tb/tb_demux4_tdm.sv
module tb_demux4_tdm;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux4_tdm_if #(.WIDTH(W)) bus ();
  demux4_tdm #(.WIDTH(W)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Reference model: frame assembly as a queue of received slots.
  bit           m_locked = 0;
  logic [W-1:0] part[$];
  logic [15:0]  m_y = '0;
  bit           m_fv = 0, m_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit v, input bit s, input logic [W-1:0] d);
    m_fv = 0; m_err = 0;
    if (r) begin
      m_locked = 0; part.delete(); m_y = '0;
    end else if (v) begin
      if (!m_locked) begin
        if (s) begin part.delete(); part.push_back(d); m_locked = 1; end
      end else if (s) begin
        m_err = (part.size() != 0);
        part.delete(); part.push_back(d);
      end else if (part.size() == 0) begin
        m_err = 1; m_locked = 0;
      end else begin
        part.push_back(d);
        if (part.size() == 4) begin
          m_y = {part[3], part[2], part[1], part[0]};
          m_fv = 1;
          part.delete();
        end
      end
    end
  endtask

  // One clock: drive, advance model, compare every output after the edge.
  task automatic step(input bit r, input bit v, input bit s, input logic [W-1:0] d);
    rst = r; bus.valid_i = v; bus.sync_i = s; bus.d_i = d;
    @(posedge clk);
    model(r, v, s, d);
    #1;
    chk("y",      bus.y_o,           m_y);
    chk("fv",     bus.frame_valid_o, m_fv);
    chk("locked", bus.locked_o,      m_locked);
    chk("slot",   bus.slot_o,        part.size());
    chk("err",    bus.sync_err_o,    m_err);
    if (bus.frame_valid_o && bus.sync_err_o) chk("fv_err_excl", 1, 0);
  endtask

  task automatic frame(input logic [15:0] f, input bit gaps);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, k == 0, f[k*4 +: 4]);
      if (gaps && k < 3) step(0, 0, 0, 4'h0);
    end
  endtask

  initial begin
    bus.d_i = '0; bus.valid_i = 0; bus.sync_i = 0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_y", bus.y_o, 0);
    chk("rst_locked", bus.locked_o, 0);

    // Aligned frame A,B,C,D
    frame(16'hDCBA, 0);
    chk("aligned_y", bus.y_o, 16'hDCBA);
    chk("aligned_fv", bus.frame_valid_o, 1);
    chk("aligned_locked", bus.locked_o, 1);
    step(0, 0, 0, 0);
    chk("aligned_fv_drop", bus.frame_valid_o, 0);

    // Hunt discard
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 4'(i + 7));
    chk("hunt_locked", bus.locked_o, 0);
    chk("hunt_err", bus.sync_err_o, 0);
    frame(16'h4321, 0);
    chk("hunt_y", bus.y_o, 16'h4321);
    chk("hunt_fv", bus.frame_valid_o, 1);

    // Gapped frame
    frame(16'h8765, 1);
    chk("gap_y", bus.y_o, 16'h8765);
    chk("gap_fv", bus.frame_valid_o, 1);

    // Early sync on slot 2
    step(0, 1, 1, 4'h9);
    step(0, 1, 0, 4'hA);
    step(0, 1, 1, 4'hB);
    chk("early_err", bus.sync_err_o, 1);
    chk("early_slot", bus.slot_o, 1);
    step(0, 1, 0, 4'hC);
    step(0, 1, 0, 4'hD);
    chk("early_hold", bus.y_o, 16'h8765);
    step(0, 1, 0, 4'hE);
    chk("early_y", bus.y_o, 16'hEDCB);

    // Missing sync
    step(0, 1, 0, 4'h1);
    chk("miss_err", bus.sync_err_o, 1);
    chk("miss_locked", bus.locked_o, 0);
    chk("miss_y", bus.y_o, 16'hEDCB);

    // Reset mid-frame
    step(0, 1, 1, 4'h3);
    step(0, 1, 0, 4'h4);
    step(1, 1, 0, 4'h5);
    chk("mrst_y", bus.y_o, 0);
    chk("mrst_locked", bus.locked_o, 0);
    chk("mrst_slot", bus.slot_o, 0);
    frame(16'hF0E1, 0);
    chk("mrst_frame", bus.y_o, 16'hF0E1);

    // Random stream: mostly well-formed, with occasional framing faults/resets
    for (int i = 0; i < 3000; i++) begin
      bit v, s, r;
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 9) < 7);
      if (part.size() == 0) s = ($urandom_range(0, 9) != 0);
      else                  s = ($urandom_range(0, 14) == 0);
      step(r, v, s, 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
